// File: rtl/dmux1to8_16bit_buf_pkg.sv
// dmux1to8_16bit_buf_pkg: shared constants, channel index type and bit count helper
package dmux1to8_16bit_buf_pkg;
    localparam int CH_COUNT = 8;
    localparam int SEL_W = 3;
    localparam int DEF_WIDTH = 16;
    typedef logic [SEL_W-1:0] ch_idx_t;
    function automatic logic [3:0] popcount(input logic [CH_COUNT-1:0] v);
        popcount = '0;
        for (int i = 0; i < CH_COUNT; i++) popcount += {3'b0, v[i]};
    endfunction
endpackage

// File: rtl/dmux1to8_16bit_buf_chan_reg.sv
// dmux_chan_reg: one-entry holding register with valid flag and consumer handshake
module dmux_chan_reg
    import dmux1to8_16bit_buf_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr,
    input  logic             flush,
    input  logic             ready,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] data,
    output logic             valid,
    output logic             valid_nxt
);
    // flush wins over delivery; a write during delivery keeps valid set with no bubble
    always_comb valid_nxt = flush ? 1'b0 : wr ? 1'b1 : (valid && ready) ? 1'b0 : valid;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data  <= '0;
            valid <= 1'b0;
        end else begin
            valid <= valid_nxt;
            if (wr) data <= wdata;
        end
    end
endmodule

// File: rtl/dmux1to8_16bit_buf.sv
// dmux1to8_16bit_buf: registered 1-to-8 demux with per-channel holding registers
module dmux1to8_16bit_buf
    import dmux1to8_16bit_buf_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [WIDTH-1:0]    in_data,
    input  ch_idx_t             in_sel,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic                rr_mode,
    input  logic                flush,
    output logic [WIDTH-1:0]    out0,
    output logic [WIDTH-1:0]    out1,
    output logic [WIDTH-1:0]    out2,
    output logic [WIDTH-1:0]    out3,
    output logic [WIDTH-1:0]    out4,
    output logic [WIDTH-1:0]    out5,
    output logic [WIDTH-1:0]    out6,
    output logic [WIDTH-1:0]    out7,
    output logic [CH_COUNT-1:0] out_valid,
    input  logic [CH_COUNT-1:0] out_ready,
    output ch_idx_t             rr_ptr,
    output logic [3:0]          occupancy
);
    logic [WIDTH-1:0]    data [CH_COUNT];
    logic [CH_COUNT-1:0] valid_nxt;
    ch_idx_t             dst;
    logic                accept;
    always_comb begin
        dst      = rr_mode ? rr_ptr : in_sel;
        in_ready = !flush && (!out_valid[dst] || out_ready[dst]);
        accept   = in_valid && in_ready;
    end
    for (genvar i = 0; i < CH_COUNT; i++) begin : g_ch
        dmux_chan_reg #(.WIDTH(WIDTH)) u_ch (
            .clk       (clk),
            .rst       (rst),
            .wr        (accept && dst == ch_idx_t'(i)),
            .flush     (flush),
            .ready     (out_ready[i]),
            .wdata     (in_data),
            .data      (data[i]),
            .valid     (out_valid[i]),
            .valid_nxt (valid_nxt[i])
        );
    end
    assign out0 = data[0];
    assign out1 = data[1];
    assign out2 = data[2];
    assign out3 = data[3];
    assign out4 = data[4];
    assign out5 = data[5];
    assign out6 = data[6];
    assign out7 = data[7];
    // occupancy tracks the next-state valids so it never lags out_valid
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_ptr    <= '0;
            occupancy <= '0;
        end else begin
            occupancy <= popcount(valid_nxt);
            if (accept && rr_mode) rr_ptr <= rr_ptr + 3'd1;
        end
    end
endmodule

// File: tb/tb_dmux1to8_16bit_buf.sv
// tb_dmux1to8_16bit_buf: directed self-checking bench for the 1-to-8 demux
module tb_dmux1to8_16bit_buf;
    logic        clk = 0, rst = 0, in_valid = 0, rr_mode = 0, flush = 0, in_ready;
    logic [15:0] in_data = '0;
    logic [2:0]  in_sel = '0, rr_ptr;
    logic [7:0]  out_ready = '0, out_valid;
    logic [3:0]  occupancy;
    logic [15:0] out0, out1, out2, out3, out4, out5, out6, out7;
    logic [15:0] outs [8];
    logic [15:0] vec [8] = '{16'hFFFF, 16'h0000, 16'hFE00, 16'h01FF, 16'h11FF, 16'h01F7, 16'h41F7, 16'hC1FF};
    int total = 0, bad = 0;

    always #5 clk = ~clk;

    assign outs[0] = out0;
    assign outs[1] = out1;
    assign outs[2] = out2;
    assign outs[3] = out3;
    assign outs[4] = out4;
    assign outs[5] = out5;
    assign outs[6] = out6;
    assign outs[7] = out7;

    dmux1to8_16bit_buf dut (
        .clk(clk), .rst(rst), .in_data(in_data), .in_sel(in_sel), .in_valid(in_valid),
        .in_ready(in_ready), .rr_mode(rr_mode), .flush(flush),
        .out0(out0), .out1(out1), .out2(out2), .out3(out3),
        .out4(out4), .out5(out5), .out6(out6), .out7(out7),
        .out_valid(out_valid), .out_ready(out_ready), .rr_ptr(rr_ptr), .occupancy(occupancy)
    );

    task test_reset;
        #1 rst = 1;
        #1;
        total++; if (out_valid !== 8'h00) begin bad++; $display("FAIL reset_valid got=%h exp=00", out_valid); end
        total++; if (occupancy !== 4'd0 || rr_ptr !== 3'd0) begin bad++; $display("FAIL reset_cnt occ=%0d ptr=%0d exp=0/0", occupancy, rr_ptr); end
        total++; if ((out0 | out1 | out2 | out3 | out4 | out5 | out6 | out7) !== 16'h0) begin bad++; $display("FAIL reset_data got nonzero exp=0000"); end
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_ready got=%b exp=1", in_ready); end
        @(posedge clk); #1 rst = 0;
    endtask

    task test_fill;
        for (int s = 0; s < 8; s++) begin
            in_sel = 3'(s); in_data = vec[s]; in_valid = 1;
            #1;
            total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL fill_ready sel=%0d got=%b exp=1", s, in_ready); end
            @(posedge clk); #1 in_valid = 0;
            total++; if (out_valid !== 8'((1 << (s + 1)) - 1)) begin bad++; $display("FAIL fill_valid sel=%0d got=%h exp=%h", s, out_valid, 8'((1 << (s + 1)) - 1)); end
            total++; if (outs[s] !== vec[s]) begin bad++; $display("FAIL fill_data sel=%0d got=%h exp=%h", s, outs[s], vec[s]); end
            total++; if (occupancy !== 4'(s + 1)) begin bad++; $display("FAIL fill_occ sel=%0d got=%0d exp=%0d", s, occupancy, s + 1); end
        end
        for (int s = 0; s < 8; s++) begin
            in_sel = 3'(s); in_valid = 1;
            #1;
            total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL full_ready sel=%0d got=%b exp=0", s, in_ready); end
        end
        in_valid = 0;
    endtask

    task test_passthrough;
        out_ready = 8'h08; in_sel = 3'd3; in_data = 16'hABCD; in_valid = 1;
        #1;
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL pass_ready got=%b exp=1", in_ready); end
        @(posedge clk); #1 in_valid = 0; out_ready = 8'h00;
        total++; if (out3 !== 16'hABCD) begin bad++; $display("FAIL pass_data got=%h exp=abcd", out3); end
        total++; if (out_valid !== 8'hFF || occupancy !== 4'd8) begin bad++; $display("FAIL pass_valid got=%h/%0d exp=ff/8", out_valid, occupancy); end
    endtask

    task test_back_to_back;
        out_ready = 8'hFF; rr_mode = 1; in_valid = 1;
        for (int i = 1; i <= 10; i++) begin
            in_data = 16'(i);
            #1;
            total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL rr_ready word=%0d got=%b exp=1", i, in_ready); end
            @(posedge clk); #1;
            total++; if (outs[(i - 1) % 8] !== 16'(i)) begin bad++; $display("FAIL rr_data word=%0d ch=%0d got=%h exp=%h", i, (i - 1) % 8, outs[(i - 1) % 8], 16'(i)); end
        end
        in_valid = 0;
        total++; if (rr_ptr !== 3'd2) begin bad++; $display("FAIL rr_ptr got=%0d exp=2", rr_ptr); end
        total++; if (out_valid !== 8'h02 || occupancy !== 4'd1) begin bad++; $display("FAIL rr_valid got=%h/%0d exp=02/1", out_valid, occupancy); end
        @(posedge clk); #1;
        total++; if (out_valid !== 8'h00 || occupancy !== 4'd0) begin bad++; $display("FAIL rr_drain got=%h/%0d exp=00/0", out_valid, occupancy); end
        rr_mode = 0; out_ready = 8'h00;
    endtask

    task test_stall;
        in_sel = 3'd5; in_data = 16'h5555; in_valid = 1;
        @(posedge clk); #1 in_data = 16'h1234;
        for (int c = 0; c < 4; c++) begin
            total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL stall_ready cyc=%0d got=%b exp=0", c, in_ready); end
            @(posedge clk); #1;
            total++; if (out5 !== 16'h5555 || out_valid !== 8'h20 || occupancy !== 4'd1) begin bad++; $display("FAIL stall_hold cyc=%0d got=%h/%h/%0d exp=5555/20/1", c, out5, out_valid, occupancy); end
        end
        out_ready = 8'h20;
        #1;
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL stall_release got=%b exp=1", in_ready); end
        @(posedge clk); #1 in_valid = 0; out_ready = 8'h00;
        total++; if (out5 !== 16'h1234 || out_valid !== 8'h20 || rr_ptr !== 3'd2) begin bad++; $display("FAIL stall_accept got=%h/%h/%0d exp=1234/20/2", out5, out_valid, rr_ptr); end
    endtask

    task test_flush;
        for (int c = 0; c < 6; c += 2) begin
            in_sel = 3'(c); in_data = {8'hA0 | 8'(c), 8'hA0 | 8'(c)}; in_valid = 1;
            @(posedge clk); #1;
        end
        total++; if (out_valid !== 8'h35 || occupancy !== 4'd4) begin bad++; $display("FAIL flush_pre got=%h/%0d exp=35/4", out_valid, occupancy); end
        flush = 1; in_sel = 3'd1; in_data = 16'h9999;
        #1;
        total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL flush_ready got=%b exp=0", in_ready); end
        @(posedge clk); #1 flush = 0; in_valid = 0;
        total++; if (out_valid !== 8'h00 || occupancy !== 4'd0) begin bad++; $display("FAIL flush_valid got=%h/%0d exp=00/0", out_valid, occupancy); end
        total++; if (rr_ptr !== 3'd2) begin bad++; $display("FAIL flush_ptr got=%0d exp=2", rr_ptr); end
        total++; if (out0 !== 16'hA0A0 || out1 !== 16'h000A || out4 !== 16'hA4A4 || out5 !== 16'h1234) begin bad++; $display("FAIL flush_data got=%h/%h/%h/%h exp=a0a0/000a/a4a4/1234", out0, out1, out4, out5); end
    endtask

    task test_async_reset;
        in_sel = 3'd6; in_data = 16'h6666; in_valid = 1;
        @(posedge clk); #1 in_valid = 0;
        total++; if (out6 !== 16'h6666 || out_valid !== 8'h40) begin bad++; $display("FAIL areset_pre got=%h/%h exp=6666/40", out6, out_valid); end
        #2 rst = 1;
        #1;
        total++; if (out_valid !== 8'h00 || occupancy !== 4'd0 || rr_ptr !== 3'd0) begin bad++; $display("FAIL areset_ctl got=%h/%0d/%0d exp=00/0/0", out_valid, occupancy, rr_ptr); end
        total++; if ((out0 | out1 | out2 | out3 | out4 | out5 | out6 | out7) !== 16'h0) begin bad++; $display("FAIL areset_data got=%h/%h exp=0000", out6, out0); end
        @(posedge clk); #1 rst = 0;
    endtask

    initial begin
        test_reset;
        test_fill;
        test_passthrough;
        test_back_to_back;
        test_stall;
        test_flush;
        test_async_reset;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/dmux1to8_16bit_buf.md
Name: dmux1to8_16bit_buf

Overview:
- Registered 1-to-8 demultiplexer: the distribution counterpart of the 8-to-1 16-bit mux.
- Accepts one WIDTH-bit word per cycle on a valid/ready input port and steers it to one of eight output channels.
- Each output channel has a one-entry holding register with its own valid/ready handshake.
- Sits between a single producer and eight independent consumers.
- Destination is either an explicit select or an internal round-robin pointer.

Parameters:
- WIDTH, 16, data width of the input word and of each output channel.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous reset, active-high.
- in_data  input  WIDTH  word to distribute.
- in_sel  input  3  destination channel when rr_mode=0.
- in_valid  input  1  producer has a word.
- in_ready  output  1  block can accept the word this cycle.
- rr_mode  input  1  1 = destination taken from the internal round-robin pointer; in_sel is ignored.
- flush  input  1  synchronous clear of all channel valids.
- out0..out7  output  WIDTH each  channel holding registers.
- out_valid  output  8  bit k = outk holds an undelivered word.
- out_ready  input  8  bit k = consumer k takes outk this cycle.
- rr_ptr  output  3  current round-robin pointer.
- occupancy  output  4  number of set bits in out_valid (0..8).

Behaviour:
- Reset (asynchronous, rst=1): out0..out7=0, out_valid=0, rr_ptr=0, occupancy=0. in_ready follows its combinational equation, so it is 1 under reset unless flush is held.
- Destination dst = rr_mode ? rr_ptr : in_sel.
- in_ready = !flush && (!out_valid[dst] || out_ready[dst]).
  - Combinational from out_ready, which gives pass-through throughput of one word per cycle per channel.
- Accept = in_valid && in_ready.
- On accept, at the next edge: out<dst> <= in_data and out_valid[dst] <= 1. Latency is one cycle from accept to visibility.
- Channel k delivery = out_valid[k] && out_ready[k].
  - Delivery with no new write to k: out_valid[k] <= 0.
  - outk keeps its last value; data registers are never cleared except by reset.
- Simultaneous delivery on k and accept to k: out_valid[k] stays 1 and outk takes the new word. No bubble.
- Deliveries on several channels in the same cycle are independent; all complete.
- Unselected channels hold data and valid unchanged.
- rr_ptr increments by 1 on every accept while rr_mode=1, wrapping 7->0. It does not move in explicit mode or on a stalled cycle.
- rr_mode may change on any cycle; the new value takes effect in the same cycle. rr_ptr is retained across mode changes.
- flush=1: at the next edge out_valid <= 0.
  - No accept occurs in that cycle, because in_ready is 0.
  - rr_ptr and data registers are unchanged.
  - flush has priority over deliveries.
- occupancy is registered and consistent with out_valid on every cycle: it is updated in the same edge using the next-state count.
- Stall with in_valid=1 and in_ready=0: no state change. The producer must hold in_data and in_sel stable, per the handshake.
- Reset asserted mid-operation immediately clears all state; pending words are lost.
- in_sel and in_data are don't-care when in_valid=0.

Decomposition:
- Shared package holds:
  - the CH_COUNT=8 and SEL_W=3 constants;
  - the default WIDTH=16;
  - a channel-index typedef for sel and rr_ptr.
- One natural sub-module: dmux_chan_reg. It is the per-channel holding register plus valid flag and handshake, instantiated 8 times.
- Top level holds dst selection, in_ready generation, rr_ptr, flush and occupancy.

Test Plan:
- Reset, then for sel=0..7 drive in_data=16'hFFFF,16'h0000,16'hFE00,16'h01FF,16'h11FF,16'h01F7,16'h41F7,16'hC1FF with out_ready=0 -> one cycle after each accept, only out_valid[sel] newly set and outk equals the value sent to it; occupancy ends at 8 and in_ready=0 for every sel.
- Channel 3 full, out_ready[3]=1, write 16'hABCD to sel=3 in the same cycle -> in_ready=1, out3=16'hABCD next cycle, out_valid[3] stays 1, occupancy unchanged.
- rr_mode=1, 10 back-to-back words 1..10, all out_ready=1 -> words go to channels 0,1,...,7,0,1; rr_ptr ends at 2.
- Channel 5 full, out_ready[5]=0, drive in_valid with in_sel=5 for 4 cycles -> in_ready=0, no state change; raise out_ready[5] -> accept in that cycle.
- Four channels full, assert flush one cycle with in_valid=1 -> in_ready=0, out_valid=0 and occupancy=0 next cycle, data registers and rr_ptr unchanged.
- Assert rst asynchronously mid-stream between clock edges -> all outputs 0 immediately, without waiting for a clock edge.
